// File: rtl/ras_lifo_pkg.sv
// ras_lifo_pkg: operation encoding and parameter helpers shared by the return-address stack.
package ras_lifo_pkg;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } op_e;

   function automatic bit is_pow2(input int v);
      return v > 0 && (v & (v - 1)) == 0;
   endfunction

endpackage

// File: rtl/ras_lifo_mem.sv
// ras_lifo_mem: unreset entry array with one write port and one asynchronous read port.
module ras_lifo_mem #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] ram_q [DEPTH];

   always_ff @(posedge clk)
      if (we_i) ram_q[waddr_i] <= wdata_i;

   assign rdata_o = ram_q[raddr_i];

endmodule

// File: rtl/ras_lifo.sv
// ras_lifo: circular return-address stack; overflow overwrites the oldest entry,
// top of stack is shown ahead on dout with din bypassed while empty.
module ras_lifo
   import ras_lifo_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("ras_lifo: DEPTH must be a power of two and at least 2");
   end

   logic [AW-1:0]    wp_q, wp_d, top, waddr;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, we;
   logic [WIDTH-1:0] rdata;
   op_e              op;

   assign op    = op_e'({push, pop});
   assign top   = wp_q - AW'(1);
   assign empty = cnt_q == '0;
   assign full  = cnt_q == CW'(DEPTH);

   // wp wraps naturally, so the oldest slot is reused once the stack is full
   always_comb begin
      wp_d  = wp_q;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      we    = 1'b0;
      waddr = wp_q;
      case (op)
         OP_PUSH: begin
            we    = 1'b1;
            wp_d  = wp_q + AW'(1);
            ovf_d = full;
            cnt_d = full ? cnt_q : cnt_q + CW'(1);
         end
         OP_POP: begin
            wp_d  = empty ? wp_q : top;
            cnt_d = empty ? cnt_q : cnt_q - CW'(1);
            unf_d = empty;
         end
         OP_REPL: begin
            we    = !empty;
            waddr = top;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end

   ras_lifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (din),
      .raddr_i (top),
      .rdata_o (rdata)
   );

   assign dout      = empty ? din : rdata;
   assign count     = cnt_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_ras_lifo.sv
// tb_ras_lifo: random and directed stack traffic against a queue-based reference,
// expectations queued by the driver and compared by an independent negedge monitor.
module tb_ras_lifo;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0;
   logic [WIDTH-1:0] din = '0, dout;
   logic             empty, full, overflow, underflow;
   logic [CW-1:0]    count;
   bit               clk_en = 1'b0;

   always #5 if (clk_en) clk = ~clk;

   ras_lifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   typedef struct {
      logic [31:0] dout;
      logic [31:0] count;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned stk[$];
   bit          m_ovf, m_unf;
   int          checks = 0, errors = 0;

   function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, act, req);
      end
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      e.dout  = stk.size() == 0 ? 32'(din) : stk[stk.size() - 1];
      e.count = stk.size();
      e.empty = stk.size() == 0;
      e.full  = stk.size() == DEPTH;
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      return e;
   endfunction

   function automatic void model_step(input bit p, input bit q, input int unsigned d);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (p && q) begin
         if (stk.size() != 0) stk[stk.size() - 1] = d;
      end else if (p) begin
         if (stk.size() == DEPTH) begin
            void'(stk.pop_front());
            m_ovf = 1'b1;
         end
         stk.push_back(d);
      end else if (q) begin
         if (stk.size() != 0) void'(stk.pop_back());
         else m_unf = 1'b1;
      end
   endfunction

   function automatic void model_reset();
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   // called off-edge; the queued expectation is checked at the negedge before the edge that acts
   task automatic drive(input bit p, input bit q, input logic [WIDTH-1:0] d);
      push = p;
      pop  = q;
      din  = d;
      exp_q.push_back(expect_now());
      @(posedge clk);
      model_step(p, q, 32'(d));
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("dout", 32'(dout), e.dout);
         chk("count", 32'(count), e.count);
         chk("empty", 32'(empty), 32'(e.empty));
         chk("full", 32'(full), 32'(e.full));
         chk("overflow", 32'(overflow), 32'(e.ovf));
         chk("underflow", 32'(underflow), 32'(e.unf));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      din = 8'hA5;
      #2;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_dout_a5", 32'(dout), 32'hA5);
      din = 8'h3C;
      #1;
      chk("rst_dout_3c", 32'(dout), 32'h3C);
      rst = 1'b0;
      model_reset();
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 8'(i));
      repeat (3) drive(1'b0, 1'b1, 8'h55);
      drive(1'b0, 1'b0, 8'h66);
      for (int i = 10; i <= 14; i++) drive(1'b1, 1'b0, 8'(i));
      repeat (4) drive(1'b0, 1'b1, 8'h77);
      drive(1'b0, 1'b0, 8'h88);
      repeat (2) drive(1'b0, 1'b1, 8'h99);
      drive(1'b0, 1'b0, 8'h11);
      drive(1'b1, 1'b0, 8'h0A);
      drive(1'b1, 1'b0, 8'h0B);
      drive(1'b1, 1'b1, 8'h0C);
      drive(1'b0, 1'b0, 8'h22);
      repeat (2) drive(1'b0, 1'b1, 8'h33);
      drive(1'b1, 1'b1, 8'h44);
      drive(1'b0, 1'b0, 8'h45);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'($urandom));
      push = 1'b0;
      pop  = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      rst = 1'b0;
      model_reset();
      drive(1'b1, 1'b0, 8'h07);
      drive(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 600; i++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      drive(1'b0, 1'b0, 8'h5A);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
